minicpu_ctrl: RTL and testbench
===============================

Name: minicpu_ctrl

Overview:
- Multi-cycle fetch/decode/execute controller for the MiniCPU.
- Sits directly upstream of the two-register file (Reg A / Reg B) and produces its we_a, we_b and data_in.
- Fetches 8-bit instructions from a synchronous-read program ROM and uses a combinational ALU result for arithmetic write-back.
- Maintains the PC, the instruction register (IR) and the zero flag.

Parameters:
- PC_W, 4, program-counter / ROM address width; must be >= 4.
- DATA_W, 8, data path width; must match the register file and ALU.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  level; 1 = execute program, 0 = stop at the next instruction boundary
- rom_addr  out  PC_W  program ROM address (= pc)
- rom_data  in  8  ROM read data, valid one cycle after rom_addr
- alu_result  in  DATA_W  combinational ALU output computed from Reg A and Reg B
- alu_op  out  1  0 = add, 1 = sub; valid in EXEC
- we_a  out  1  write enable, Reg A
- we_b  out  1  write enable, Reg B
- data_in  out  DATA_W  write data to the register file
- halted  out  1  HALT executed
- busy  out  1  state != IDLE and state != HALT

Behaviour:
- Instruction format: opcode = ir[7:4], imm = ir[3:0].
- Opcodes:
  - 0 NOP
  - 1 LDA (A <= zero-extended imm)
  - 2 LDB (B <= zero-extended imm)
  - 3 ADD (A <= alu_result)
  - 4 SUB (A <= alu_result)
  - 5 JMP (pc <= imm)
  - 6 JZ (pc <= imm if z = 1)
  - F HALT
  - All other opcodes execute as NOP.
- States:
  - IDLE: if run = 1, go to FETCH; otherwise stay in IDLE.
  - FETCH: rom_addr = pc; go to DECODE.
  - DECODE: ir <= rom_data; go to EXEC.
  - EXEC: go to FETCH if run = 1, otherwise IDLE. If the opcode is HALT, go to HALT instead.
  - HALT: absorbing; left only by reset.
- Timing: each instruction takes 3 cycles. The register-file write occurs on the clock edge that ends EXEC.
- Outputs during EXEC:
  - we_a, we_b, data_in and alu_op are combinational from state and ir, and are active only in EXEC.
  - Outside EXEC, we_a = we_b = 0, data_in = 0 and alu_op = 0.
  - LDA/LDB: data_in = {0, imm}.
  - ADD/SUB: data_in = alu_result; alu_op = opcode == SUB.
- Never assert we_a and we_b in the same cycle.
- PC update at the end of EXEC:
  - pc <= pc + 1, wrapping from 2^PC_W - 1 to 0.
  - JMP, and JZ with z = 1: pc <= zero-extended imm.
  - HALT: pc is unchanged.
- Zero flag: z <= (alu_result == 0) at the end of EXEC for ADD/SUB only; all other opcodes hold z.
- Arithmetic is modulo 2^DATA_W. The ALU owns the arithmetic; the controller passes alu_result through.
- run deasserted mid-instruction: the current instruction completes, then the controller enters IDLE with pc pointing at the next instruction. Reasserting run resumes from that pc.
- halted: 1 in the HALT state.
- Reset (asynchronous, at any point including mid-EXEC):
  - state = IDLE; pc = 0, ir = 0, z = 0.
  - All outputs 0: we_a = we_b = 0, data_in = 0, halted = 0, busy = 0, alu_op = 0, rom_addr = 0.
  - No write is issued on the reset cycle.

Decomposition:
- Shared package minicpu_pkg holds:
  - opcode localparams OP_NOP … OP_HALT
  - state encoding (IDLE, FETCH, DECODE, EXEC, HALT)
  - ALU op constants (ALU_ADD = 0, ALU_SUB = 1)
- Single module. The EXEC decode is a pure function; no sub-module is warranted.

Test Plan:
- Reset, then run = 1 with ROM[0] = 8'h15 (LDA 5) -> we_a high for exactly one cycle at cycle 3 with data_in = 8'h05; we_b = 0; pc = 1.
- ROM = LDA 3, LDB 3, SUB, JZ 7, HALT…, ROM[7] = HALT; ALU model A − B -> z = 1 after SUB, pc = 7 after JZ, halted = 1, we_a/we_b stay 0 afterwards.
- ROM = LDA 15, LDB 1, ADD, with the ALU modelling an 8-bit add -> A written with 8'h10 and z = 0; a second ADD repeated until wrap checks that 8'hFF + 1 writes 8'h00 and sets z = 1.
- ROM filled with NOP at PC_W = 4 -> pc runs 15 → 0 wrap; opcode 8'h9x behaves as NOP with no writes.
- Deassert run during DECODE of instruction 2 -> instruction 2 completes, controller enters IDLE with busy = 0 and pc = 3; reassert run -> next fetch uses address 3.
- Assert rst_n = 0 during EXEC of an LDB -> we_b drops immediately, pc = 0, state IDLE, halted = 0.

Source files
------------

// File: rtl/minicpu_pkg.sv
// Shared definitions for the MiniCPU controller: opcodes, FSM encoding, ALU ops
// and the EXEC-stage instruction decoder.
package minicpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef struct packed {
        logic we_a;
        logic we_b;
        logic sel_alu;
        logic sel_imm;
        logic alu_op;
        logic upd_z;
        logic jmp;
        logic jz;
        logic halt;
    } exec_dec_t;

    // Control decode of one opcode; unknown opcodes fall through to all-zero (NOP).
    function automatic exec_dec_t exec_decode(input logic [3:0] opcode);
        exec_dec_t d;
        d = '0;
        case (opcode)
            OP_NOP: d = '0;
            OP_LDA: begin
                d.we_a    = 1'b1;
                d.sel_imm = 1'b1;
            end
            OP_LDB: begin
                d.we_b    = 1'b1;
                d.sel_imm = 1'b1;
            end
            OP_ADD: begin
                d.we_a    = 1'b1;
                d.sel_alu = 1'b1;
                d.alu_op  = ALU_ADD;
                d.upd_z   = 1'b1;
            end
            OP_SUB: begin
                d.we_a    = 1'b1;
                d.sel_alu = 1'b1;
                d.alu_op  = ALU_SUB;
                d.upd_z   = 1'b1;
            end
            OP_JMP:  d.jmp  = 1'b1;
            OP_JZ:   d.jz   = 1'b1;
            OP_HALT: d.halt = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/minicpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the MiniCPU. Owns PC, IR and
// the zero flag, and drives register-file write strobes during EXEC.
module minicpu_ctrl
    import minicpu_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [7:0]        rom_data,
    input  logic [DATA_W-1:0] alu_result,
    output logic              alu_op,
    output logic              we_a,
    output logic              we_b,
    output logic [DATA_W-1:0] data_in,
    output logic              halted,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic              z_q, z_d;

    exec_dec_t         dec_s;
    logic [PC_W-1:0]   imm_pc_s;
    logic [DATA_W-1:0] imm_data_s;

    // State, PC, IR and zero-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= 8'h00;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
        end
    end

    // Zero-extended immediate in both PC and data widths.
    always_comb begin
        imm_pc_s        = '0;
        imm_pc_s[3:0]   = ir_q[3:0];
        imm_data_s      = '0;
        imm_data_s[3:0] = ir_q[3:0];
        dec_s           = exec_decode(ir_q[7:4]);
    end

    // Next-state logic and EXEC-stage register-file controls.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        we_a    = 1'b0;
        we_b    = 1'b0;
        data_in = '0;
        alu_op  = ALU_ADD;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = rom_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                we_a   = dec_s.we_a;
                we_b   = dec_s.we_b;
                alu_op = dec_s.alu_op;
                if (dec_s.sel_alu) begin
                    data_in = alu_result;
                end else if (dec_s.sel_imm) begin
                    data_in = imm_data_s;
                end else begin
                    data_in = '0;
                end
                if (dec_s.upd_z) begin
                    z_d = (alu_result == '0);
                end else begin
                    z_d = z_q;
                end
                // HALT freezes the PC so rom_addr keeps pointing at the HALT.
                if (dec_s.halt) begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end else begin
                    if (dec_s.jmp || (dec_s.jz && z_q)) begin
                        pc_d = imm_pc_s;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                    if (run) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom_addr = pc_q;
    assign halted   = (state_q == ST_HALT);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_minicpu_ctrl.sv
// Directed self-checking bench for minicpu_ctrl with a behavioural ROM,
// register file (Reg A / Reg B) and 8-bit add/sub ALU.
module tb_minicpu_ctrl;
    import minicpu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] alu_result;
    logic       alu_op;
    logic       we_a;
    logic       we_b;
    logic [7:0] data_in;
    logic       halted;
    logic       busy;

    logic [7:0] rom [16];
    logic [7:0] reg_a;
    logic [7:0] reg_b;
    int         wa_cnt;
    int         wb_cnt;
    int         both_cnt;
    logic [7:0] last_wa_data;

    int n_tests;
    int n_fail;
    int wa0;
    int wb0;

    minicpu_ctrl #(.PC_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .alu_result (alu_result),
        .alu_op     (alu_op),
        .we_a       (we_a),
        .we_b       (we_b),
        .data_in    (data_in),
        .halted     (halted),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    assign alu_result = alu_op ? (reg_a - reg_b) : (reg_a + reg_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a <= 8'h00;
            reg_b <= 8'h00;
        end else begin
            if (we_a) reg_a <= data_in;
            if (we_b) reg_b <= data_in;
        end
    end

    initial begin
        wa_cnt       = 0;
        wb_cnt       = 0;
        both_cnt     = 0;
        last_wa_data = 8'h00;
    end

    always @(posedge clk) begin
        if (we_a) begin
            wa_cnt       <= wa_cnt + 1;
            last_wa_data <= data_in;
        end
        if (we_b) wb_cnt <= wb_cnt + 1;
        if (we_a && we_b) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset, load a ROM image of all HALT, then caller patches entries.
    task automatic enter_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        run     = 1'b0;

        // ---- Test 1: reset state, then LDA 5
        enter_reset();
        rom[0] = 8'h15;
        chk("rst_busy",     busy,     32'h0);
        chk("rst_halted",   halted,   32'h0);
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_we_a",     we_a,     32'h0);
        chk("rst_we_b",     we_b,     32'h0);
        chk("rst_data_in",  data_in,  32'h0);
        chk("rst_alu_op",   alu_op,   32'h0);
        wa0 = wa_cnt;
        rst_n = 1'b1; run = 1'b1;
        cyc(1);
        chk("t1_busy_fetch", busy, 32'h1);
        chk("t1_we_a_c1",    we_a, 32'h0);
        cyc(1);
        chk("t1_we_a_c2",    we_a, 32'h0);
        cyc(1);
        chk("t1_we_a_exec",  we_a,    32'h1);
        chk("t1_data_in",    data_in, 32'h05);
        chk("t1_we_b_exec",  we_b,    32'h0);
        cyc(1);
        chk("t1_we_a_after", we_a,     32'h0);
        chk("t1_pc",         rom_addr, 32'h1);
        chk("t1_reg_a",      reg_a,    32'h05);
        chk("t1_wa_pulses",  wa_cnt - wa0, 32'h1);
        cyc(3);
        chk("t1_halted",     halted,   32'h1);
        chk("t1_busy_halt",  busy,     32'h0);
        chk("t1_pc_halt",    rom_addr, 32'h1);

        // ---- Test 2: LDA 3, LDB 3, SUB, JZ 7 -> HALT at 7
        enter_reset();
        rom[0] = 8'h13; rom[1] = 8'h23; rom[2] = 8'h40; rom[3] = 8'h67;
        rst_n = 1'b1; run = 1'b1;
        cyc(9);
        chk("t2_sub_we_a",   we_a,    32'h1);
        chk("t2_sub_alu_op", alu_op,  32'h1);
        chk("t2_sub_data",   data_in, 32'h00);
        cyc(3);
        chk("t2_jz_we_a",    we_a,    32'h0);
        chk("t2_jz_we_b",    we_b,    32'h0);
        chk("t2_jz_alu_op",  alu_op,  32'h0);
        cyc(1);
        chk("t2_jz_taken",   rom_addr, 32'h7);
        cyc(3);
        chk("t2_halted",     halted,   32'h1);
        chk("t2_pc_halt",    rom_addr, 32'h7);
        wa0 = wa_cnt; wb0 = wb_cnt;
        cyc(5);
        chk("t2_no_wa_halt", wa_cnt - wa0, 32'h0);
        chk("t2_no_wb_halt", wb_cnt - wb0, 32'h0);
        chk("t2_halt_stays", halted,       32'h1);

        // ---- Test 3: LDA 15, LDB 1, loop ADD until wrap to zero
        enter_reset();
        rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h30; rom[3] = 8'h65; rom[4] = 8'h52;
        wa0 = wa_cnt;
        rst_n = 1'b1; run = 1'b1;
        cyc(9);
        chk("t3_add_we_a",   we_a,    32'h1);
        chk("t3_add_data",   data_in, 32'h10);
        chk("t3_add_alu_op", alu_op,  32'h0);
        cyc(4);
        chk("t3_z0_no_jump", rom_addr, 32'h4);
        for (int i = 0; i < 5000 && !halted; i++) @(negedge clk);
        chk("t3_halt_reached", halted,       32'h1);
        chk("t3_exit_pc",      rom_addr,     32'h5);
        chk("t3_wrap_data",    last_wa_data, 32'h00);
        chk("t3_reg_a_zero",   reg_a,        32'h00);
        chk("t3_wa_total",     wa_cnt - wa0, 32'd242);

        // ---- Test 4: NOPs with an undefined opcode; PC wraps 15 -> 0
        enter_reset();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[3] = 8'h9A;
        wa0 = wa_cnt; wb0 = wb_cnt;
        rst_n = 1'b1; run = 1'b1;
        cyc(12);
        chk("t4_9x_we_a", we_a,    32'h0);
        chk("t4_9x_we_b", we_b,    32'h0);
        chk("t4_9x_data", data_in, 32'h0);
        cyc(34);
        chk("t4_pc_15",   rom_addr, 32'hF);
        cyc(3);
        chk("t4_pc_wrap", rom_addr, 32'h0);
        chk("t4_no_wa",   wa_cnt - wa0, 32'h0);
        chk("t4_no_wb",   wb_cnt - wb0, 32'h0);

        // ---- Test 5: drop run during DECODE of instruction 2, then resume
        enter_reset();
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h13; rom[3] = 8'h24;
        rst_n = 1'b1; run = 1'b1;
        cyc(8);
        run = 1'b0;
        cyc(1);
        chk("t5_i2_we_a",   we_a,    32'h1);
        chk("t5_i2_data",   data_in, 32'h03);
        cyc(1);
        chk("t5_idle_busy", busy,     32'h0);
        chk("t5_idle_pc",   rom_addr, 32'h3);
        chk("t5_idle_hlt",  halted,   32'h0);
        chk("t5_reg_a",     reg_a,    32'h03);
        cyc(3);
        chk("t5_still_idle", busy,     32'h0);
        chk("t5_still_pc",   rom_addr, 32'h3);
        run = 1'b1;
        cyc(1);
        chk("t5_resume_busy", busy,     32'h1);
        chk("t5_resume_addr", rom_addr, 32'h3);
        cyc(2);
        chk("t5_i3_we_b",     we_b,    32'h1);
        chk("t5_i3_data",     data_in, 32'h04);

        // ---- Test 6: asynchronous reset in the middle of an LDB EXEC
        enter_reset();
        rom[0] = 8'h00; rom[1] = 8'h25;
        rst_n = 1'b1; run = 1'b1;
        cyc(6);
        chk("t6_ldb_we_b", we_b,     32'h1);
        chk("t6_ldb_pc",   rom_addr, 32'h1);
        wb0 = wb_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we_b",   we_b,     32'h0);
        chk("t6_rst_pc",     rom_addr, 32'h0);
        chk("t6_rst_busy",   busy,     32'h0);
        chk("t6_rst_halted", halted,   32'h0);
        chk("t6_rst_data",   data_in,  32'h0);
        cyc(1);
        chk("t6_no_write",   wb_cnt - wb0, 32'h0);
        chk("t6_never_both", both_cnt,     32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
